// File: rtl/uart_burst_tx_if.sv
// CPU-side write bus of the burst UART transmitter: data/strobes in, status flags out.
interface uart_burst_tx_if #(
    parameter int NBYTES = 4
);
    logic [8*NBYTES-1:0] d;
    logic                wrtx;
    logic                wrbaud;
    logic                thre;
    logic                tend;
    logic                ovf;

    modport master (output d, wrtx, wrbaud, input thre, tend, ovf);
    modport slave  (input d, wrtx, wrbaud, output thre, tend, ovf);
endinterface

// File: rtl/uart_burst_tx.sv
// UART transmitter with a word FIFO; each word carries 1..NBYTES bytes sent back-to-back.
// Optional even-parity bit between DATA and STOP when UARTB_PARITY_EN is defined.
module uart_burst_tx #(
    parameter int NBYTES  = 4,
    parameter int DIV_W   = 9,
    parameter int DIV_RST = 7,
    parameter int DEPTH   = 2
) (
    input  logic           clk,
    input  logic           rstn,
    uart_burst_tx_if.slave bus,
    output logic           txd
);
    localparam int LEN_W = $clog2(NBYTES);
    localparam int NB_W  = LEN_W + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 8 * NBYTES;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UARTB_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DIV_W-1:0] div_reg;
    logic             mode_reg;
    logic [LEN_W-1:0] blen_reg;

    logic [DW-1:0]    word_mem [DEPTH];
    logic [NB_W-1:0]  nb_mem   [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             full, empty, push_ok, pop;
    logic [NB_W-1:0]  nb_in;

    logic [2:0]       state_reg, state_next;
    logic [DIV_W-1:0] baud_reg, baud_next;
    logic [DIV_W-1:0] div_lat_reg, div_lat_next;
    logic [2:0]       bit_reg, bit_next;
    logic [DW-1:0]    word_reg, word_next;
    logic [NB_W-1:0]  left_reg, left_next;
    logic             txd_reg, txd_next;
    logic             thre_reg, tend_reg, ovf_reg;
    logic             baud_done;
    logic [7:0]       cur_byte;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    // A pop in the same edge frees a slot, so a push into a full FIFO is still taken.
    assign push_ok   = bus.wrtx && (!full || pop);
    assign nb_in     = mode_reg ? (NB_W'(blen_reg) + NB_W'(1)) : NB_W'(1);
    assign baud_done = (baud_reg == div_lat_reg);
    assign cur_byte  = word_reg[7:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_reg  <= DIV_W'(DIV_RST);
            mode_reg <= 1'b0;
            blen_reg <= '0;
        end else if (bus.wrbaud) begin
            div_reg  <= bus.d[DIV_W-1:0];
            mode_reg <= bus.d[DW-1];
            blen_reg <= bus.d[DW-2 -: LEN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            word_mem[wr_ptr_reg] <= bus.d;
            nb_mem[wr_ptr_reg]   <= nb_in;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + (AW+1)'(1);
        else if (!push_ok && pop)
            count_next = count_reg - (AW+1)'(1);
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        div_lat_next = div_lat_reg;
        bit_next     = bit_reg;
        word_next    = word_reg;
        left_next    = left_reg;
        txd_next     = txd_reg;
        pop          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                    bit_next   = 3'd0;
                    baud_next  = '0;
                    txd_next   = cur_byte[0];
                end else begin
                    baud_next = baud_reg + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
`ifdef UARTB_PARITY_EN
                        state_next = S_PARITY;
                        txd_next   = ^cur_byte;
`else
                        state_next = S_STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        txd_next = cur_byte[bit_reg + 3'd1];
                    end
                end else begin
                    baud_next = baud_reg + DIV_W'(1);
                end
            end
`ifdef UARTB_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                    txd_next   = 1'b1;
                end else begin
                    baud_next = baud_reg + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    if (left_reg != '0) begin
                        // Next byte of the same word: shift it down and restart with the current divider.
                        state_next   = S_START;
                        word_next    = word_reg >> 8;
                        left_next    = left_reg - NB_W'(1);
                        baud_next    = '0;
                        div_lat_next = div_reg;
                        txd_next     = 1'b0;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_next = baud_reg + DIV_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                txd_next   = 1'b1;
            end
        endcase
        if (pop) begin
            state_next   = S_START;
            word_next    = word_mem[rd_ptr_reg];
            left_next    = nb_mem[rd_ptr_reg] - NB_W'(1);
            baud_next    = '0;
            div_lat_next = div_reg;
            txd_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            state_reg   <= S_IDLE;
            baud_reg    <= '0;
            div_lat_reg <= '0;
            bit_reg     <= '0;
            word_reg    <= '0;
            left_reg    <= '0;
            txd_reg     <= 1'b1;
            thre_reg    <= 1'b1;
            tend_reg    <= 1'b1;
            ovf_reg     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg   <= count_next;
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            div_lat_reg <= div_lat_next;
            bit_reg     <= bit_next;
            word_reg    <= word_next;
            left_reg    <= left_next;
            txd_reg     <= txd_next;
            thre_reg    <= (count_next != (AW+1)'(DEPTH));
            tend_reg    <= (state_next == S_IDLE) && (count_next == '0);
            // A dropped word outranks a clearing config write in the same cycle.
            if (bus.wrtx && !push_ok)
                ovf_reg <= 1'b1;
            else if (bus.wrbaud)
                ovf_reg <= 1'b0;
        end
    end

    assign txd      = txd_reg;
    assign bus.thre = thre_reg;
    assign bus.tend = tend_reg;
    assign bus.ovf  = ovf_reg;
endmodule
